// File: rtl/stopwatch_counter.sv
// ============================================================================
// stopwatch_counter : tenth-second prescaler and MM:SS.t BCD time counter
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_counter #(
  parameter int PRESCALE   = 3277,
  parameter int PRESCALE_W = 12
) (
  input  logic       Crystal,
  input  logic       nSysReset,
  input  logic       WatchRunning,
  input  logic       WatchReset,
  output logic [3:0] Tenths,
  output logic [3:0] SecsLo,
  output logic [3:0] SecsHi,
  output logic [3:0] MinsLo,
  output logic [3:0] MinsHi,
  output logic       Tick,
  output logic       Overflow
);

  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(PRESCALE - 1);
  localparam logic [PRESCALE_W-1:0] PRESCALE_ONE  = PRESCALE_W'(1);

  // Returns {carry_out, next_digit} for a BCD digit that rolls over after max.
  function automatic logic [4:0] bcd_step(input logic [3:0] digit, input logic [3:0] max);
    if (digit == max) begin
      bcd_step = {1'b1, 4'd0};
    end else begin
      bcd_step = {1'b0, digit + 4'd1};
    end
  endfunction

  logic [PRESCALE_W-1:0] prescaler_q, prescaler_d;
  logic [3:0]            tenths_q,  tenths_d;
  logic [3:0]            secs_lo_q, secs_lo_d;
  logic [3:0]            secs_hi_q, secs_hi_d;
  logic [3:0]            mins_lo_q, mins_lo_d;
  logic [3:0]            mins_hi_q, mins_hi_d;
  logic                  tick_q,    tick_d;
  logic                  overflow_q, overflow_d;

  logic [4:0] step_t, step_sl, step_sh, step_ml, step_mh;
  logic       advance;
  logic       carry_sl, carry_sh, carry_ml, carry_mh, wrap;

  // Every digit's successor is precomputed so the whole carry chain settles in one edge.
  always_comb begin
    step_t  = bcd_step(tenths_q,  4'd9);
    step_sl = bcd_step(secs_lo_q, 4'd9);
    step_sh = bcd_step(secs_hi_q, 4'd5);
    step_ml = bcd_step(mins_lo_q, 4'd9);
    step_mh = bcd_step(mins_hi_q, 4'd5);
  end

  always_comb begin
    advance  = WatchRunning && (prescaler_q == PRESCALE_LAST);
    carry_sl = advance  && step_t[4];
    carry_sh = carry_sl && step_sl[4];
    carry_ml = carry_sh && step_sh[4];
    carry_mh = carry_ml && step_ml[4];
    wrap     = carry_mh && step_mh[4];
  end

  always_comb begin
    prescaler_d = prescaler_q;
    tenths_d    = tenths_q;
    secs_lo_d   = secs_lo_q;
    secs_hi_d   = secs_hi_q;
    mins_lo_d   = mins_lo_q;
    mins_hi_d   = mins_hi_q;
    tick_d      = 1'b0;
    overflow_d  = overflow_q;

    if (WatchReset) begin
      prescaler_d = '0;
      tenths_d    = 4'd0;
      secs_lo_d   = 4'd0;
      secs_hi_d   = 4'd0;
      mins_lo_d   = 4'd0;
      mins_hi_d   = 4'd0;
      overflow_d  = 1'b0;
    end else if (WatchRunning) begin
      prescaler_d = advance ? '0 : prescaler_q + PRESCALE_ONE;
      tick_d      = advance;
      if (advance)  tenths_d  = step_t[3:0];
      if (carry_sl) secs_lo_d = step_sl[3:0];
      if (carry_sh) secs_hi_d = step_sh[3:0];
      if (carry_ml) mins_lo_d = step_ml[3:0];
      if (carry_mh) mins_hi_d = step_mh[3:0];
      if (wrap)     overflow_d = 1'b1;
    end
  end

  always_ff @(posedge Crystal or negedge nSysReset) begin
    if (!nSysReset) begin
      prescaler_q <= '0;
      tenths_q    <= 4'd0;
      secs_lo_q   <= 4'd0;
      secs_hi_q   <= 4'd0;
      mins_lo_q   <= 4'd0;
      mins_hi_q   <= 4'd0;
      tick_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      tenths_q    <= tenths_d;
      secs_lo_q   <= secs_lo_d;
      secs_hi_q   <= secs_hi_d;
      mins_lo_q   <= mins_lo_d;
      mins_hi_q   <= mins_hi_d;
      tick_q      <= tick_d;
      overflow_q  <= overflow_d;
    end
  end

  assign Tenths   = tenths_q;
  assign SecsLo   = secs_lo_q;
  assign SecsHi   = secs_hi_q;
  assign MinsLo   = mins_lo_q;
  assign MinsHi   = mins_hi_q;
  assign Tick     = tick_q;
  assign Overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
// ============================================================================
// tb_stopwatch_counter : directed checks of the stopwatch time counter
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic run_a, clr_a, run_b, clr_b;
  logic [3:0] t_a, sl_a, sh_a, ml_a, mh_a;
  logic [3:0] t_b, sl_b, sh_b, ml_b, mh_b;
  logic tick_a, ovf_a, tick_b, ovf_b;
  logic [19:0] time_a, time_b;

  int n_vec  = 0;
  int n_miss = 0;
  int tick_cnt_a = 0;
  int chg_cnt_a  = 0;
  logic [19:0] prev_a;

  // Main instance at the bench prescale; second instance exercises PRESCALE=1 and the wrap.
  stopwatch_counter #(.PRESCALE(4), .PRESCALE_W(3)) u_dut_a (
    .Crystal(clk), .nSysReset(rst_n), .WatchRunning(run_a), .WatchReset(clr_a),
    .Tenths(t_a), .SecsLo(sl_a), .SecsHi(sh_a), .MinsLo(ml_a), .MinsHi(mh_a),
    .Tick(tick_a), .Overflow(ovf_a)
  );

  stopwatch_counter #(.PRESCALE(1), .PRESCALE_W(1)) u_dut_b (
    .Crystal(clk), .nSysReset(rst_n), .WatchRunning(run_b), .WatchReset(clr_b),
    .Tenths(t_b), .SecsLo(sl_b), .SecsHi(sh_b), .MinsLo(ml_b), .MinsHi(mh_b),
    .Tick(tick_b), .Overflow(ovf_b)
  );

  assign time_a = {mh_a, ml_a, sh_a, sl_a, t_a};
  assign time_b = {mh_b, ml_b, sh_b, sl_b, t_b};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, leaving the bench 1 time unit after the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (tick_a === 1'b1) tick_cnt_a++;
      if (time_a !== prev_a) chg_cnt_a++;
      prev_a = time_a;
    end
  endtask

  task automatic clear_stats();
    tick_cnt_a = 0;
    chg_cnt_a  = 0;
    prev_a     = time_a;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run_a = 1'b0; clr_a = 1'b0; run_b = 1'b0; clr_b = 1'b0;
    prev_a = '0;
    #12;
    check("reset_time_a", {12'd0, time_a}, 32'h0);
    check("reset_flags_a", {30'd0, tick_a, ovf_a}, 32'h0);
    rst_n = 1'b1;

    // Async reset mid-count: 8 running edges reach 00:00.2 with Tick just pulsed.
    @(posedge clk); #1;
    run_a = 1'b1;
    step(8);
    check("pre_async_time", {12'd0, time_a}, 32'h00002);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_time_a", {12'd0, time_a}, 32'h0);
    check("async_flags_a", {30'd0, tick_a, ovf_a}, 32'h0);
    check("async_time_b", {12'd0, time_b}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 40 running edges from clear.
    clear_stats();
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (i == 3) check("tick_before_4", {31'd0, tick_a}, 32'h0);
      if (i == 4) begin
        check("tick_after_4", {31'd0, tick_a}, 32'h1);
        check("time_after_4", {12'd0, time_a}, 32'h00001);
      end
    end
    check("run40_time", {12'd0, time_a}, 32'h00010);
    check("run40_ticks", tick_cnt_a, 32'd10);

    // Stop/resume keeps the partial tenth.
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    check("clear_time", {12'd0, time_a}, 32'h0);
    step(6);
    check("run6_time", {12'd0, time_a}, 32'h00001);
    run_a = 1'b0;
    clear_stats();
    step(10);
    check("stop10_changes", chg_cnt_a, 32'd0);
    check("stop10_ticks", tick_cnt_a, 32'd0);
    run_a = 1'b1;
    step(1);
    check("resume1_time", {12'd0, time_a}, 32'h00001);
    step(1);
    check("resume2_time", {12'd0, time_a}, 32'h00002);
    check("resume2_tick", {31'd0, tick_a}, 32'h1);

    // Reach 00:12.3 plus a partial tenth, then synchronous clear while running.
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    step(494);
    check("t12_3_time", {12'd0, time_a}, 32'h00123);
    clr_a = 1'b1;
    step(1);
    check("wreset_time", {12'd0, time_a}, 32'h0);
    check("wreset_flags", {30'd0, tick_a, ovf_a}, 32'h0);
    clr_a = 1'b0;
    step(3);
    check("after_clr3_time", {12'd0, time_a}, 32'h0);
    step(1);
    check("after_clr4_time", {12'd0, time_a}, 32'h00001);

    // Hold for 100 edges.
    run_a = 1'b0;
    clear_stats();
    step(100);
    check("hold100_changes", chg_cnt_a, 32'd0);
    check("hold100_ticks", tick_cnt_a, 32'd0);
    check("hold100_time", {12'd0, time_a}, 32'h00001);

    // Wrap on the PRESCALE=1 instance: one tenth per running edge.
    run_b = 1'b1;
    step(1);
    check("b_first_time", {12'd0, time_b}, 32'h00001);
    check("b_first_tick", {31'd0, tick_b}, 32'h1);
    step(35998);
    check("b_5959_9_time", {12'd0, time_b}, 32'h59599);
    check("b_5959_9_ovf", {31'd0, ovf_b}, 32'h0);
    step(1);
    check("b_wrap_time", {12'd0, time_b}, 32'h0);
    check("b_wrap_ovf", {31'd0, ovf_b}, 32'h1);
    step(1);
    check("b_post_wrap_time", {12'd0, time_b}, 32'h00001);
    check("b_post_wrap_ovf", {31'd0, ovf_b}, 32'h1);
    run_b = 1'b0;
    step(5);
    check("b_hold_ovf", {31'd0, ovf_b}, 32'h1);
    check("b_hold_tick", {31'd0, tick_b}, 32'h0);
    clr_b = 1'b1;
    step(1);
    clr_b = 1'b0;
    check("b_clr_ovf", {31'd0, ovf_b}, 32'h0);
    check("b_clr_time", {12'd0, time_b}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
